plant_emu: RTL and testbench
============================

PLANT_EMU -- requirements
Module: plant_emu

Interface
REQ-001 The block SHALL have parameter DEC_W, default 14, giving the decimation counter width.
REQ-002 The block SHALL have parameter DLY_DEPTH, default 16, giving the number of transport-delay entries (power of two).
REQ-003 The block SHALL have port clk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port enable_i, input, 1, the run enable.
REQ-006 The block SHALL have port act_i, input, 14, the unsigned actuator code (DAC-format, mid-scale 8191).
REQ-007 The block SHALL have port decimate_i, input, DEC_W, the update period in clocks.
REQ-008 The block SHALL have port delay_i, input, log2(DLY_DEPTH), the transport delay in ticks.
REQ-009 The block SHALL have port alpha_i, input, 4, the pole shift; filter coefficient = 2^-alpha.
REQ-010 The block SHALL have port gain_i, input, signed 16, the plant gain in Q1.14 (16384 = unity).
REQ-011 The block SHALL have port offset_i, input, signed 16, the sensor offset.
REQ-012 The block SHALL have port noise_shift_i, input, 4, the noise attenuation shift.
REQ-013 The block SHALL have port dat_o, output, signed 16, the emulated sensor sample.
REQ-014 The block SHALL have port valid_o, output, 1, a one-cycle pulse marking a new dat_o.
REQ-015 The block SHALL have port sat_o, output, 1, set when the latest update clipped.

Function
REQ-016 Config latch: while enable_i=1, decimate_i, delay_i, alpha_i, gain_i, offset_i and noise_shift_i SHALL be registered every cycle; decimate_i=0 is treated as 1.
REQ-017 Tick: tick = enable_i AND cnt==0; cnt SHALL wrap to 0 when cnt >= decimate-1 and increment otherwise.
REQ-018 Conversion: a = act_i - 8191 SHALL be formed as signed 15-bit, range -8191..+8192.
REQ-019 Delay, edge E (tick): a SHALL be written to a circular buffer; tap = value written delay ticks earlier; delay=0 means tap = a.
REQ-020 Delay changes SHALL take effect on the next tick without clearing the buffer.
REQ-021 Gain, edge E: g = (gain * tap) >>> 14 from a 32-bit product, saturated to signed 16, SHALL be registered.
REQ-022 Filter, edge E+1: y = y + ((g - y) >>> alpha), computed in 17 bits and saturated to signed 16.
REQ-023 Output, edge E+1: dat_o = sat16(y + offset [+ noise]).
REQ-024 Output, edge E+1: sat_o = 1 if any saturation occurred in that update's path, else 0.
REQ-025 Output, edge E+1: valid_o SHALL be 1 for exactly the cycle following E+1.
REQ-026 Latency: an act_i value sampled on a tick edge SHALL appear on dat_o at the next edge when delay=0.
REQ-027 With decimate=1, ticks on consecutive edges SHALL pipeline with no bubbles, so valid_o stays high continuously.
REQ-028 Disable: when enable_i=0, cnt, buffer, g, y, dat_o, valid_o and sat_o SHALL clear to 0 at the next edge; the config registers SHALL hold.
REQ-029 Re-enable: the first tick SHALL occur on the first enabled edge.
REQ-030 Outside ticks, y, dat_o and sat_o SHALL hold their values.

Reset
REQ-031 On rst_n=0 at an edge, dat_o, valid_o, sat_o, cnt, g, y, the buffer and all config registers SHALL clear to 0, except decimate = 1.
REQ-032 With NOISE_EN, reset SHALL also set the LFSR to 16'hACE1.
REQ-033 Reset SHALL take priority over enable_i, including mid-pipeline: no valid_o pulse follows reset.

Configuration
REQ-034 Macro PLANT_EMU_NOISE_EN defined: a 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, SHALL advance once per tick.
REQ-035 Macro PLANT_EMU_NOISE_EN defined: noise = $signed(lfsr) >>> noise_shift_i SHALL be added before the output saturation.
REQ-036 Macro PLANT_EMU_NOISE_EN undefined: no LFSR SHALL exist, noise_shift_i is ignored, and noise = 0.

Verification
REQ-037 Reset hold: rst_n=0 with enable_i=1, act_i=16383 -> dat_o=0, valid_o=0 and sat_o=0 every cycle.
REQ-038 Unity step: decimate=1, delay=0, alpha=0, gain=16384, offset=0, act 8191->9191 -> dat_o=1000 one edge after the step, sat_o=0.
REQ-039 Delay and filter: delay=3, alpha=1, same step -> dat_o stays 0 for 3 ticks, then 500, 750, 875, 937.
REQ-040 Saturation: gain=32767, act=16383, offset=32000 -> dat_o=32767, sat_o=1; act=0, offset=-32000 -> dat_o=-32768, sat_o=1.
REQ-041 Decimation and disable: decimate=4 -> one valid_o every 4 clocks; enable_i dropped mid-run -> dat_o=0 next edge; re-enable -> valid_o at the second enabled edge.
REQ-042 Noise (PLANT_EMU_NOISE_EN): act=8191, gain=0, noise_shift=15 -> dat_o in {-1,0}; noise_shift=0 -> first tick's dat_o equals $signed(16'hACE1 advanced once).

Source files
------------

// File: rtl/plant_emu_if.sv
// rtl/plant_emu_if.sv - plant emulator config, actuator and sensor signal bundle
interface plant_emu_if #(
    parameter int DEC_W     = 14,
    parameter int DLY_DEPTH = 16
);
    localparam int DLY_W = $clog2(DLY_DEPTH);

    logic                enable_i;
    logic [13:0]         act_i;
    logic [DEC_W-1:0]    decimate_i;
    logic [DLY_W-1:0]    delay_i;
    logic [3:0]          alpha_i;
    logic signed [15:0]  gain_i;
    logic signed [15:0]  offset_i;
    logic [3:0]          noise_shift_i;
    logic signed [15:0]  dat_o;
    logic                valid_o;
    logic                sat_o;

    modport master (
        output enable_i, act_i, decimate_i, delay_i, alpha_i, gain_i, offset_i, noise_shift_i,
        input  dat_o, valid_o, sat_o
    );

    modport slave (
        input  enable_i, act_i, decimate_i, delay_i, alpha_i, gain_i, offset_i, noise_shift_i,
        output dat_o, valid_o, sat_o
    );
endinterface

// File: rtl/plant_emu.sv
// rtl/plant_emu.sv - first-order plant emulator with transport delay; PLANT_EMU_NOISE_EN adds LFSR sensor noise
module plant_emu #(
    parameter int DEC_W     = 14,
    parameter int DLY_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    plant_emu_if.slave  bus
);
    localparam int DLY_W = $clog2(DLY_DEPTH);

    // Returns {clipped_flag, value} for a signed value clamped to 16 bits.
    function automatic logic [16:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return {1'b1, 16'h7fff};
        else if (v < -32'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, v[15:0]};
    endfunction

    logic [DEC_W-1:0]    dec_r;
    logic [DLY_W-1:0]    delay_r;
    logic [3:0]          alpha_r;
    logic signed [15:0]  gain_r;
    logic signed [15:0]  offset_r;

    logic [DEC_W-1:0]    cnt;
    logic [DLY_W-1:0]    wptr;
    logic signed [14:0]  dly_buf [DLY_DEPTH];
    logic signed [15:0]  g_r;
    logic                g_sat_r;
    logic                tick_d;
    logic signed [15:0]  y_r;
    logic signed [15:0]  dat_r;
    logic                valid_r;
    logic                sat_r;

    logic                tick;
    logic [DEC_W-1:0]    dec_last;
    logic signed [14:0]  a;
    logic [DLY_W-1:0]    rd_idx;
    logic signed [14:0]  tap;
    logic signed [31:0]  prod;
    logic [16:0]         g_full;
    logic signed [16:0]  diff;
    logic signed [16:0]  step;
    logic signed [16:0]  ysum;
    logic [16:0]         y_full;
    logic signed [15:0]  y_next;
    logic signed [15:0]  noise;
    logic signed [17:0]  osum;
    logic [16:0]         o_full;

    assign tick     = bus.enable_i && (cnt == '0);
    assign dec_last = (dec_r == '0) ? '0 : dec_r - 1'b1;
    assign a        = $signed({1'b0, bus.act_i} - 15'd8191);
    assign rd_idx   = wptr - delay_r;
    assign tap      = (delay_r == '0) ? a : dly_buf[rd_idx];
    assign prod     = $signed({{16{gain_r[15]}}, gain_r}) * $signed({{17{tap[14]}}, tap});
    assign g_full   = sat16(prod >>> 14);

    // The filter step always lands between y and g, so 17 bits hold it exactly.
    assign diff     = $signed({g_r[15], g_r}) - $signed({y_r[15], y_r});
    assign step     = diff >>> alpha_r;
    assign ysum     = $signed({y_r[15], y_r}) + step;
    assign y_full   = sat16({{15{ysum[16]}}, ysum});
    assign y_next   = y_full[15:0];
    assign osum     = $signed({{2{y_next[15]}}, y_next}) + $signed({{2{offset_r[15]}}, offset_r})
                    + $signed({{2{noise[15]}}, noise});
    assign o_full   = sat16({{14{osum[17]}}, osum});

`ifdef PLANT_EMU_NOISE_EN
    logic [15:0]         lfsr;
    logic [3:0]          noise_shift_r;
    logic signed [15:0]  lfsr_s;

    assign lfsr_s = lfsr;
    assign noise  = lfsr_s >>> noise_shift_r;

    // Galois form of x^16+x^14+x^13+x^11+1; holds while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr          <= 16'hACE1;
            noise_shift_r <= '0;
        end else if (bus.enable_i) begin
            noise_shift_r <= bus.noise_shift_i;
            if (tick)
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    assign noise = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_r    <= DEC_W'(1);
            delay_r  <= '0;
            alpha_r  <= '0;
            gain_r   <= '0;
            offset_r <= '0;
            cnt      <= '0;
            wptr     <= '0;
            for (int i = 0; i < DLY_DEPTH; i++)
                dly_buf[i] <= '0;
            g_r      <= '0;
            g_sat_r  <= 1'b0;
            tick_d   <= 1'b0;
            y_r      <= '0;
            dat_r    <= '0;
            valid_r  <= 1'b0;
            sat_r    <= 1'b0;
        end else if (!bus.enable_i) begin
            cnt      <= '0;
            wptr     <= '0;
            for (int i = 0; i < DLY_DEPTH; i++)
                dly_buf[i] <= '0;
            g_r      <= '0;
            g_sat_r  <= 1'b0;
            tick_d   <= 1'b0;
            y_r      <= '0;
            dat_r    <= '0;
            valid_r  <= 1'b0;
            sat_r    <= 1'b0;
        end else begin
            dec_r    <= bus.decimate_i;
            delay_r  <= bus.delay_i;
            alpha_r  <= bus.alpha_i;
            gain_r   <= bus.gain_i;
            offset_r <= bus.offset_i;
            cnt      <= (cnt >= dec_last) ? '0 : cnt + 1'b1;
            if (tick) begin
                dly_buf[wptr] <= a;
                wptr          <= wptr + 1'b1;
                g_r           <= g_full[15:0];
                g_sat_r       <= g_full[16];
            end
            // Second pipeline stage: filter and output for the previous tick.
            tick_d  <= tick;
            valid_r <= tick_d;
            if (tick_d) begin
                y_r   <= y_next;
                dat_r <= o_full[15:0];
                sat_r <= g_sat_r | y_full[16] | o_full[16];
            end
        end
    end

    assign bus.dat_o   = dat_r;
    assign bus.valid_o = valid_r;
    assign bus.sat_o   = sat_r;
endmodule

// File: tb/tb_plant_emu.sv
// tb/tb_plant_emu.sv - scoreboard bench for plant_emu against a tick-level reference model
module tb_plant_emu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    plant_emu_if #(.DEC_W(14), .DLY_DEPTH(16)) bus ();
    plant_emu #(.DEC_W(14), .DLY_DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int dat; bit sat; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   valid_seen = 0;

    // Reference model: registered config, tick counter, act history per tick, filter state.
    int   m_dec, m_delay, m_alpha, m_gain, m_offset, m_ns;
    int   m_cnt, m_g, m_y, m_lfsr;
    bit   m_gsat, m_pend;
    int   m_hist[$];

    function automatic int clip16(input longint v, output bit f);
        f = (v > 32767) || (v < -32768);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic check(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, req);
        end
    endtask

    task automatic model_edge();
        bit fy, fo;
        int a, tap, o, nz, ls;
        if (!rst_n) begin
            m_dec = 1; m_delay = 0; m_alpha = 0; m_gain = 0; m_offset = 0; m_ns = 0;
            m_cnt = 0; m_g = 0; m_gsat = 0; m_y = 0; m_pend = 0; m_lfsr = 'hACE1;
            m_hist.delete();
        end else if (!bus.enable_i) begin
            m_cnt = 0; m_g = 0; m_gsat = 0; m_y = 0; m_pend = 0;
            m_hist.delete();
        end else begin
            if (m_pend) begin
                m_y = clip16(longint'(m_y) + ((m_g - m_y) >>> m_alpha), fy);
                nz = 0;
`ifdef PLANT_EMU_NOISE_EN
                ls = (m_lfsr >= 32768) ? m_lfsr - 65536 : m_lfsr;
                nz = ls >>> m_ns;
`else
                ls = 0;
`endif
                o = clip16(longint'(m_y) + m_offset + nz + ls * 0, fo);
                exp_q.push_back('{o, m_gsat | fy | fo});
            end
            m_pend = (m_cnt == 0);
            if (m_pend) begin
                a = int'(bus.act_i) - 8191;
                m_hist.push_front(a);
                if (m_hist.size() > 16) void'(m_hist.pop_back());
                tap = (m_delay == 0) ? a : ((m_delay < m_hist.size()) ? m_hist[m_delay] : 0);
                m_g = clip16((longint'(m_gain) * tap) >>> 14, m_gsat);
                m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
            end
            m_cnt = (m_cnt >= ((m_dec == 0) ? 1 : m_dec) - 1) ? 0 : m_cnt + 1;
            m_dec = int'(bus.decimate_i); m_delay = int'(bus.delay_i); m_alpha = int'(bus.alpha_i);
            m_gain = int'(bus.gain_i); m_offset = int'(bus.offset_i); m_ns = int'(bus.noise_shift_i);
        end
    endtask

    task automatic set_cfg(input int dec, input int dly, input int alpha, input int gain,
                           input int offset, input int ns);
        bus.decimate_i    = 14'(dec);
        bus.delay_i       = 4'(dly);
        bus.alpha_i       = 4'(alpha);
        bus.gain_i        = 16'(gain);
        bus.offset_i      = 16'(offset);
        bus.noise_shift_i = 4'(ns);
    endtask

    task automatic drive(input bit rst, input bit en, input int act);
        rst_n        = rst;
        bus.enable_i = en;
        bus.act_i    = 14'(act);
        model_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got dat=%0d with no expected sample", bus.dat_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dat", longint'(bus.dat_o), e.dat);
                    check("sb_sat", bus.sat_o, e.sat);
                end
            end
        end
    end

    initial begin
        int dly_exp[7];
        int v0;
        dly_exp = '{0, 0, 0, 500, 750, 875, 937};

        set_cfg(1, 0, 0, 16384, 0, 15);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 16383);
            check("reset_dat", longint'(bus.dat_o), 0);
            check("reset_valid", bus.valid_o, 0);
            check("reset_sat", bus.sat_o, 0);
        end

        repeat (4) drive(1'b1, 1'b1, 8191);
        drive(1'b1, 1'b1, 9191);
        drive(1'b1, 1'b1, 9191);
`ifndef PLANT_EMU_NOISE_EN
        check("unity_step_dat", longint'(bus.dat_o), 1000);
`endif
        check("unity_step_sat", bus.sat_o, 0);
        check("unity_step_valid", bus.valid_o, 1);

        drive(1'b1, 1'b0, 8191);
        set_cfg(1, 3, 1, 16384, 0, 15);
        repeat (4) drive(1'b1, 1'b1, 8191);
        drive(1'b1, 1'b1, 9191);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 9191);
`ifndef PLANT_EMU_NOISE_EN
            check("delay_filter_dat", longint'(bus.dat_o), dly_exp[i]);
`endif
        end

        set_cfg(1, 0, 0, 32767, 32000, 15);
        repeat (4) drive(1'b1, 1'b1, 16383);
        check("sat_hi_dat", longint'(bus.dat_o), 32767);
        check("sat_hi_flag", bus.sat_o, 1);
        set_cfg(1, 0, 0, 32767, -32000, 15);
        repeat (4) drive(1'b1, 1'b1, 0);
        check("sat_lo_dat", longint'(bus.dat_o), -32768);
        check("sat_lo_flag", bus.sat_o, 1);

        set_cfg(4, 0, 0, 16384, 0, 15);
        repeat (8) drive(1'b1, 1'b1, 9191);
        v0 = valid_seen;
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, int'($urandom_range(0, 16383)));
        check("decim_valid_count", valid_seen - v0, 10);

        drive(1'b1, 1'b0, 9191);
        check("disable_dat", longint'(bus.dat_o), 0);
        check("disable_valid", bus.valid_o, 0);
        check("disable_sat", bus.sat_o, 0);
        drive(1'b1, 1'b1, 9191);
        check("reenable_first_valid", bus.valid_o, 0);
        drive(1'b1, 1'b1, 9191);
        check("reenable_second_valid", bus.valid_o, 1);

`ifdef PLANT_EMU_NOISE_EN
        drive(1'b0, 1'b1, 8191);
        set_cfg(1, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 8191);
        drive(1'b1, 1'b1, 8191);
        check("noise_first_tick", longint'(bus.dat_o), -7568);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)) - 32768,
                        int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)));
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) != 0),
                  int'($urandom_range(0, 16383)));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
